bcd_seq_ctrl: RTL and testbench
===============================

Name: bcd_seq_ctrl

Overview:
- Sequential binary-to-BCD conversion controller for the 9-bit switch-to-3-digit 7-segment display path.
- Samples a binary operand on a start request and runs a shift-and-add-3 (double-dabble) sequence, one bit per clock.
- Latches the resulting BCD digits and their active-low 7-segment codes and signals completion with a one-cycle done pulse.
- Replaces the wide combinational comparator chain with a small FSM plus datapath, and can self-trigger when the switch value changes.

Parameters:
- WIDTH, 9, binary operand width. The digit count is fixed at 3, so WIDTH ≤ 9.
- AUTO_RESTART, 0, when 1, the block in IDLE starts a conversion by itself whenever bin_in differs from the last converted value.
- BLANK_LZ, 0, when 1, leading-zero hundreds/tens digits drive 8'hFF (blank). The units digit is never blanked.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  conversion request, sampled only in IDLE
- bin_in  in  WIDTH  binary operand, captured on the accepted start
- busy  out  1  high while in SHIFT state
- done  out  1  one-cycle pulse when new outputs become valid
- BCD2  out  4  hundreds digit (registered)
- BCD1  out  4  tens digit (registered)
- BCD0  out  4  units digit (registered)
- HEX2  out  8  active-low 7-seg code for BCD2 (bit7 = DP, always 1)
- HEX1  out  8  active-low 7-seg code for BCD1
- HEX0  out  8  active-low 7-seg code for BCD0

Behaviour:
- Reset (asynchronous, any state including mid-conversion):
  - state = IDLE; busy = 0, done = 0.
  - BCD2/1/0 = 0, HEX2/1/0 = 8'hC0.
  - last_val = 0, bit counter = 0, scratch registers = 0.
  - No partial result is ever published.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Trigger = start, or (AUTO_RESTART = 1 and bin_in != last_val).
  - On trigger: sh ← bin_in, scratch digits ← 0, cnt ← WIDTH, last_val ← bin_in, go to SHIFT.
  - Otherwise remain in IDLE; outputs hold.
- SHIFT (busy = 1), once per cycle:
  - Each scratch digit ≥ 5 gets +3 (4-bit, no overflow possible).
  - Then {d2, d1, d0, sh} shifts left by 1; cnt decrements.
  - When cnt reaches 1 at the edge performing the last shift, go to DONE.
- DONE (one cycle):
  - done = 1, busy = 0.
  - BCD2/1/0 and HEX2/1/0 take the new values at the edge entering DONE, so they are valid while done is high.
  - Unconditionally return to IDLE.
- Latency: start sampled at edge E; busy high for cycles E+1 … E+WIDTH; done high in cycle E+WIDTH+1 (10 cycles for WIDTH = 9). Next start is accepted in the cycle after done.
- start while busy or in DONE: ignored, not queued. bin_in changes during SHIFT do not affect the running conversion.
- start held high continuously: back-to-back conversions with one IDLE cycle between them.
- Segment map (BCD → HEX): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90; any other value → C0 (unreachable).
- Blanking (BLANK_LZ = 1): HEX2 = FF if BCD2 = 0; HEX1 = FF if BCD2 = 0 and BCD1 = 0.
- Range: max input 511 → 5/1/1; all outputs are fully registered.

Test Plan:
- Reset mid-SHIFT (assert rst 4 cycles after start of bin_in=300) -> busy=0 immediately, HEX2/1/0=C0/C0/C0, BCD=0/0/0, no done pulse; a following start with 300 yields 3/0/0.
- Directed sweep, start pulse each, bin_in = 0, 9, 35, 83, 127, 510, 511 -> done exactly 10 cycles after start, BCD 0/0/0, 0/0/9, 0/3/5, 0/8/3, 1/2/7, 5/1/0, 5/1/1; HEX for 510 = 92/F9/C0, for 127 = F9/A4/F8.
- Start during busy (bin_in=35 start, then bin_in=83 start 3 cycles later) -> single done, result 0/3/5, second start dropped.
- Continuous start high with bin_in=255 -> done pulses every 11 cycles, outputs steady 2/5/5, HEX A4/92/92.
- AUTO_RESTART=1, start tied 0, bin_in 0→42, held -> one conversion, done once, result 0/4/2; no further conversions while bin_in is stable.
- BLANK_LZ=1 with bin_in = 7, 35, 0, 105 -> HEX FF/FF/F8, FF/B0/92, FF/FF/C0, F9/C0/92.

Source files
------------

// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: sequential double-dabble binary-to-BCD converter with registered 7-segment outputs
module bcd_seq_ctrl #(
    parameter int WIDTH        = 9,
    parameter bit AUTO_RESTART = 1'b0,
    parameter bit BLANK_LZ     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD0,
    output logic [7:0]       HEX2,
    output logic [7:0]       HEX1,
    output logic [7:0]       HEX0
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] last_val;
    logic [CW-1:0]    cnt;
    logic [3:0]       d2, d1, d0;
    logic [3:0]       a2, a1, a0;
    logic [3:0]       n2, n1, n0;
    logic [7:0]       h2, h1, h0;
    logic             trig;

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hC0;
        endcase
    endfunction

    // add-3 correction, one-bit shift of the digit chain, and the segment codes of the shifted digits
    always_comb begin
        a2   = (d2 >= 4'd5) ? d2 + 4'd3 : d2;
        a1   = (d1 >= 4'd5) ? d1 + 4'd3 : d1;
        a0   = (d0 >= 4'd5) ? d0 + 4'd3 : d0;
        n2   = {a2[2:0], a1[3]};
        n1   = {a1[2:0], a0[3]};
        n0   = {a0[2:0], sh[WIDTH-1]};
        h2   = (BLANK_LZ && n2 == 4'd0) ? 8'hFF : seg(n2);
        h1   = (BLANK_LZ && n2 == 4'd0 && n1 == 4'd0) ? 8'hFF : seg(n1);
        h0   = seg(n0);
        trig = start || (AUTO_RESTART && bin_in != last_val);
    end

    // control FSM and datapath; outputs are published only on the final shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sh       <= '0;
            last_val <= '0;
            cnt      <= '0;
            d2       <= '0;
            d1       <= '0;
            d0       <= '0;
            BCD2     <= '0;
            BCD1     <= '0;
            BCD0     <= '0;
            HEX2     <= 8'hC0;
            HEX1     <= 8'hC0;
            HEX0     <= 8'hC0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        sh       <= bin_in;
                        last_val <= bin_in;
                        d2       <= '0;
                        d1       <= '0;
                        d0       <= '0;
                        cnt      <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    d2  <= n2;
                    d1  <= n1;
                    d0  <= n0;
                    sh  <= sh << 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        BCD2  <= n2;
                        BCD1  <= n1;
                        BCD0  <= n0;
                        HEX2  <= h2;
                        HEX1  <= h1;
                        HEX0  <= h0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb_bcd_seq_ctrl: scoreboard bench for bcd_seq_ctrl (plain instance plus auto-restart/blanking instance)
module tb_bcd_seq_ctrl;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         m_start = 1'b0, a_start = 1'b0;
    logic [W-1:0] m_bin = '0, a_bin = '0;
    logic         m_busy, m_done, a_busy, a_done;
    logic [3:0]   m_bcd2, m_bcd1, m_bcd0, a_bcd2, a_bcd1, a_bcd0;
    logic [7:0]   m_hex2, m_hex1, m_hex0, a_hex2, a_hex1, a_hex0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int m_dones = 0;
    int a_dones = 0;

    typedef struct {
        int          cyc;
        logic [11:0] bcd;
        logic [23:0] hex;
    } exp_t;

    exp_t mq[$];
    exp_t aq[$];

    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    bcd_seq_ctrl #(.WIDTH(W)) u_m (
        .clk(clk), .rst(rst), .start(m_start), .bin_in(m_bin),
        .busy(m_busy), .done(m_done),
        .BCD2(m_bcd2), .BCD1(m_bcd1), .BCD0(m_bcd0),
        .HEX2(m_hex2), .HEX1(m_hex1), .HEX0(m_hex0)
    );

    bcd_seq_ctrl #(.WIDTH(W), .AUTO_RESTART(1'b1), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .bin_in(a_bin),
        .busy(a_busy), .done(a_done),
        .BCD2(a_bcd2), .BCD1(a_bcd1), .BCD0(a_bcd0),
        .HEX2(a_hex2), .HEX1(a_hex1), .HEX0(a_hex0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // decimal digits by division, then table lookup and leading-zero blanking
    function automatic exp_t model(input int v, input bit blank, input int c);
        exp_t e;
        int h, t, u;
        logic [7:0] s2, s1, s0;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        s2 = (blank && h == 0) ? 8'hFF : segtab[h];
        s1 = (blank && h == 0 && t == 0) ? 8'hFF : segtab[t];
        s0 = segtab[u];
        e.cyc = c;
        e.bcd = {4'(h), 4'(t), 4'(u)};
        e.hex = {s2, s1, s0};
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    // monitor for the plain instance
    always @(negedge clk) begin : mon_m
        exp_t e;
        if (!rst && m_done) begin
            m_dones++;
            if (mq.size() == 0) check("m_spurious_done", 32'd1, 32'd0);
            else begin
                e = mq.pop_front();
                check("m_latency", 32'(cyc), 32'(e.cyc));
                check("m_bcd", 32'({m_bcd2, m_bcd1, m_bcd0}), 32'(e.bcd));
                check("m_hex", 32'({m_hex2, m_hex1, m_hex0}), 32'(e.hex));
                check("m_busy_at_done", 32'(m_busy), 32'd0);
            end
        end
    end

    // monitor for the auto-restart / blanking instance
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && a_done) begin
            a_dones++;
            if (aq.size() == 0) check("a_spurious_done", 32'd1, 32'd0);
            else begin
                e = aq.pop_front();
                check("a_latency", 32'(cyc), 32'(e.cyc));
                check("a_bcd", 32'({a_bcd2, a_bcd1, a_bcd0}), 32'(e.bcd));
                check("a_hex", 32'({a_hex2, a_hex1, a_hex0}), 32'(e.hex));
            end
        end
    end

    task automatic wait_drain(input bit auto_q);
        for (int i = 0; i < 60 && (auto_q ? aq.size() : mq.size()) != 0; i++) @(posedge clk);
        if ((auto_q ? aq.size() : mq.size()) != 0) begin
            check(auto_q ? "a_timeout" : "m_timeout", 32'(auto_q ? aq.size() : mq.size()), 32'd0);
            if (auto_q) aq.delete(); else mq.delete();
        end
        @(negedge clk);
    endtask

    task automatic conv(input int v, input int gap);
        @(negedge clk);
        m_bin = W'(v);
        m_start = 1'b1;
        mq.push_back(model(v, 1'b0, cyc + 1 + W));
        @(negedge clk);
        m_start = 1'b0;
        check("m_busy_running", 32'(m_busy), 32'd1);
        wait_drain(1'b0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic aconv(input int v);
        @(negedge clk);
        a_bin = W'(v);
        aq.push_back(model(v, 1'b1, cyc + 1 + W));
        wait_drain(1'b1);
    endtask

    initial begin
        int sweep[8] = '{0, 9, 35, 83, 127, 510, 511, 300};
        int blanks[4] = '{7, 35, 0, 105};
        int d, c0, v;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_done", 32'(m_done), 32'd0);
        check("rst_bcd", 32'({m_bcd2, m_bcd1, m_bcd0}), 32'd0);
        check("rst_hex", 32'({m_hex2, m_hex1, m_hex0}), 32'hC0C0C0);
        check("rst_a_hex", 32'({a_hex2, a_hex1, a_hex0}), 32'hC0C0C0);
        rst = 1'b0;

        foreach (sweep[i]) conv(sweep[i], 0);

        @(negedge clk);
        d = m_dones;
        m_bin = W'(300);
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(m_busy), 32'd0);
        check("midrst_bcd", 32'({m_bcd2, m_bcd1, m_bcd0}), 32'd0);
        check("midrst_hex", 32'({m_hex2, m_hex1, m_hex0}), 32'hC0C0C0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_no_done", 32'(m_dones - d), 32'd0);
        conv(300, 0);

        d = m_dones;
        @(negedge clk);
        m_bin = W'(35);
        m_start = 1'b1;
        mq.push_back(model(35, 1'b0, cyc + 1 + W));
        @(negedge clk);
        m_start = 1'b0;
        repeat (2) @(negedge clk);
        m_bin = W'(83);
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        wait_drain(1'b0);
        repeat (15) @(negedge clk);
        check("busy_start_dropped", 32'(m_dones - d), 32'd1);

        d = m_dones;
        @(negedge clk);
        m_bin = W'(255);
        m_start = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) mq.push_back(model(255, 1'b0, c0 + 1 + W + 11 * k));
        repeat (24) @(negedge clk);
        m_start = 1'b0;
        wait_drain(1'b0);
        repeat (12) @(negedge clk);
        check("continuous_dones", 32'(m_dones - d), 32'd3);

        for (int i = 0; i < 30; i++) conv(int'($urandom_range(511, 0)), int'($urandom_range(3, 0)));

        d = a_dones;
        aconv(42);
        repeat (30) @(negedge clk);
        check("auto_single_done", 32'(a_dones - d), 32'd1);

        foreach (blanks[i]) aconv(blanks[i]);

        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(511, 0));
            if (v == int'(a_bin)) v = (v + 1) % 512;
            aconv(v);
        end

        d = a_dones;
        repeat (25) @(negedge clk);
        check("auto_stable_idle", 32'(a_dones - d), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
